// File: rtl/icache.sv
// icache: three-lane, direct-mapped instruction cache with 64-bit lines.
// Lookup is combinational for all three fetch lanes. A miss starts one
// tagged load on the memory bus, and the returning line fills the array.
module icache #(
  parameter int XLEN      = 32,
  parameter int NUM_LINES = 32,
  parameter int MEM_TAG_W = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [2:0][XLEN-1:0]       proc2Icache_addr,
  input  logic [1:0]                 shift,
  input  logic                       hit_but_stall,
  output logic [2:0][31:0]           Icache_data_out,
  output logic [2:0]                 Icache_valid_out,
  output logic [1:0]                 proc2Imem_command,
  output logic [XLEN-1:0]            proc2Imem_addr,
  input  logic [MEM_TAG_W-1:0]       mem2proc_response,
  input  logic [63:0]                mem2proc_data,
  input  logic [MEM_TAG_W-1:0]       mem2proc_tag
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = XLEN - 3 - IDX_W;

  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  // Storage: valid bits are reset; tags and data are qualified by valid.
  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tags_q  [NUM_LINES];
  logic [63:0]          lines_q [NUM_LINES];

  state_t               state_q, state_d;
  logic [XLEN-1:0]      miss_addr_q, miss_addr_d;
  logic [MEM_TAG_W-1:0] miss_tag_q, miss_tag_d;
  logic                 fill_en;

  logic [2:0][IDX_W-1:0] lane_idx;
  logic [2:0][TAG_W-1:0] lane_tag;
  logic [2:0]            lane_hit;
  logic [2:0][63:0]      lane_line;

  logic                  cand_valid;
  logic [1:0]            cand_lane;
  logic [1:0]            pref_lane;
  logic [XLEN-1:0]       cand_addr;

  logic [IDX_W-1:0]      fill_idx;
  logic [TAG_W-1:0]      fill_tag;

  // Byte-offset bits and the low bits of the aligned miss address never matter.
  logic                  unused_bits;
  assign unused_bits = ^{proc2Icache_addr[2][1:0], proc2Icache_addr[1][1:0],
                         proc2Icache_addr[0][1:0], miss_addr_q[2:0]};

  // Per-lane lookup; aliasing lanes simply read the same entry.
  for (genvar gi = 0; gi < 3; gi++) begin : g_lane
    assign lane_idx[gi]  = proc2Icache_addr[gi][IDX_W+2:3];
    assign lane_tag[gi]  = proc2Icache_addr[gi][XLEN-1:IDX_W+3];
    assign lane_line[gi] = lines_q[lane_idx[gi]];
    assign lane_hit[gi]  = valid_q[lane_idx[gi]] && (tags_q[lane_idx[gi]] == lane_tag[gi]);
    assign Icache_valid_out[gi] = lane_hit[gi];
    assign Icache_data_out[gi]  = !lane_hit[gi]            ? 32'd0 :
                                  proc2Icache_addr[gi][2]  ? lane_line[gi][63:32] :
                                                             lane_line[gi][31:0];
  end

  assign fill_idx = miss_addr_q[IDX_W+2:3];
  assign fill_tag = miss_addr_q[XLEN-1:IDX_W+3];

  // Miss candidate: the lane fetch will need next first, else oldest missing lane.
  always_comb begin
    cand_valid = 1'b0;
    cand_lane  = 2'd0;
    pref_lane  = 2'd2 - shift;
    if (shift != 2'd3 && !lane_hit[pref_lane]) begin
      cand_valid = 1'b1;
      cand_lane  = pref_lane;
    end else if (!lane_hit[2]) begin
      cand_valid = 1'b1;
      cand_lane  = 2'd2;
    end else if (!lane_hit[1]) begin
      cand_valid = 1'b1;
      cand_lane  = 2'd1;
    end else if (!lane_hit[0]) begin
      cand_valid = 1'b1;
      cand_lane  = 2'd0;
    end
    cand_addr = {proc2Icache_addr[cand_lane][XLEN-1:3], 3'b000};
  end

  // Miss FSM next-state and bus outputs.
  always_comb begin
    state_d           = state_q;
    miss_addr_d       = miss_addr_q;
    miss_tag_d        = miss_tag_q;
    proc2Imem_command = BUS_NONE;
    proc2Imem_addr    = '0;
    fill_en           = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cand_valid && !hit_but_stall) begin
          miss_addr_d = cand_addr;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        proc2Imem_command = BUS_LOAD;
        proc2Imem_addr    = miss_addr_q;
        if (mem2proc_response != '0) begin
          miss_tag_d = mem2proc_response;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (miss_tag_q != '0 && mem2proc_tag == miss_tag_q) begin
          fill_en    = 1'b1;
          miss_tag_d = '0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM and miss bookkeeping registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      miss_addr_q <= '0;
      miss_tag_q  <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      miss_tag_q  <= miss_tag_d;
    end
  end

  // Valid bits: cleared on reset, set when a line fills.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag and data arrays: written only by a fill, overwriting whatever was there.
  always_ff @(posedge clock) begin
    if (fill_en) begin
      tags_q[fill_idx]  <= fill_tag;
      lines_q[fill_idx] <= mem2proc_data;
    end
  end

endmodule

// File: doc/icache.md
# icache

Three-lane instruction cache serving the 3-wide fetch stage. Each cycle it looks up the three fetch PCs combinationally and returns per-lane data plus hit flags. On a miss it runs a single-outstanding, tagged load on the instruction memory bus and fills a direct-mapped array of 64-bit lines. It sits between fetch and the memory arbiter.

## Interface
- XLEN, 32, address width
- NUM_LINES, 32, direct-mapped lines; power of two; 8 bytes (2 instructions) per line
- MEM_TAG_W, 4, memory transaction tag width; tag 0 means "no transaction"

- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- proc2Icache_addr  in  [2:0][XLEN]  fetch PCs; lane 2 is oldest (smallest PC)
- shift  in  2  lanes consumed by fetch this cycle; preferred miss lane = 2 - shift
- hit_but_stall  in  1  fetch holds on a hit; suppresses new miss requests
- Icache_data_out  out  [2:0][32]  instruction per lane
- Icache_valid_out  out  [2:0]  lane hit
- proc2Imem_command  out  2  BUS_NONE=0, BUS_LOAD=1
- proc2Imem_addr  out  XLEN  line-aligned miss address, bits [2:0]=0
- mem2proc_response  in  MEM_TAG_W  nonzero = request accepted with this tag
- mem2proc_data  in  64  returning line
- mem2proc_tag  in  MEM_TAG_W  tag of returning data; 0 = none

## Operation
- Address split: offset [2], index [2+log2(NUM_LINES):3], tag = remaining upper bits.
- Lookup, combinational, per lane i:
  - Icache_valid_out[i] = valid[idx_i] && tags[idx_i]==tag_i.
  - Icache_data_out[i] = addr[2] ? line[63:32] : line[31:0], driven only on a hit; otherwise 0.
- Miss candidate:
  - Use lane (2 - shift) if it misses.
  - Otherwise use the first missing lane in order 2, 1, 0.
  - No candidate if all lanes hit.
- FSM states: IDLE, REQ, WAIT.
  - IDLE: if a candidate exists, hit_but_stall==0, and the candidate line ≠ the line in WAIT (n/a in IDLE), latch line-aligned address into miss_addr and go to REQ. Otherwise stay.
  - REQ: drive proc2Imem_command=BUS_LOAD and proc2Imem_addr=miss_addr.
    - mem2proc_response≠0: latch it into miss_tag, go to WAIT.
    - mem2proc_response==0: stay in REQ and re-issue next cycle.
  - WAIT: command=BUS_NONE.
    - When mem2proc_tag==miss_tag and miss_tag≠0: write mem2proc_data into line[index], set tags[index] and valid[index], clear miss_tag, go to IDLE.
- Only one miss is outstanding at a time. Fetch redirects do not abort it: the fill always completes.
- Returning tags that do not match miss_tag are ignored.
- There is no forwarding of returning data: a fill becomes visible to lookup the cycle after the data returns.
- Writes happen only on fill. A fill overwrites the indexed line unconditionally (no write-back).

## Timing
- Reset values:
  - all valid bits 0
  - state IDLE
  - miss_addr 0, miss_tag 0
  - proc2Imem_command BUS_NONE, proc2Imem_addr 0
  - Icache_valid_out 0, Icache_data_out 0
- Hit latency: 0 cycles (same-cycle combinational).
- Miss timing:
  - Miss seen in cycle N → BUS_LOAD driven in cycle N+1.
  - Accepted in cycle M → data expected later with that tag.
  - Data in cycle D → lanes hit in cycle D+1.
- Reset mid-transaction returns to IDLE. A later return of the old tag is ignored because miss_tag=0.
- Same-cycle hit_but_stall=1 and miss in IDLE: no request; re-evaluated next cycle.
- Miss while in REQ or WAIT: no new request; the miss is re-detected after returning to IDLE.
- Aliasing lanes (two PCs in the same line or index) share one lookup result. One fill serves them all.

## Test plan
- Cold miss:
  - Stimulus: after reset, addr={0,4,8}, shift=0, response=1 in the REQ cycle, tag=1 returning data 0x00000013_00000093 three cycles later.
  - Response: BUS_LOAD at addr 0; lanes 2/1 valid the next cycle with 0x93/0x13; lane 0 still misses; a request for 8 follows.
- Rejection retry:
  - Stimulus: mem2proc_response=0 for 3 cycles, then 2.
  - Response: BUS_LOAD held at the same address for 4 cycles, then WAIT; only tag 2 fills.
- Stall suppression:
  - Stimulus: lane 2 hits, lane 1 misses, hit_but_stall=1.
  - Response: command stays BUS_NONE; after hit_but_stall drops, a request for lane 1's line is issued.
- Shift preference:
  - Stimulus: lanes 2 and 0 miss, shift=2.
  - Response: first request is lane 0's line.
- Stray tag:
  - Stimulus: in WAIT with miss_tag=3, tag 5 arrives with data.
  - Response: no array change, state stays WAIT; tag 3 then fills.
- Conflict and reset:
  - Stimulus: fill addr 0, then fill addr 0x100 (same index).
  - Response: addr 0 misses again.
  - Stimulus: reset asserted during WAIT.
  - Response: all lanes invalid; the late tag is ignored.
